falafel_lsu: RTL and testbench

Load/store unit for the falafel free-list allocator. It accepts one `header_data_req_t` command at a time from the allocator control FSM and translates it into single-word accesses on a memory port: header loads, header writes, and the global free-list lock spin/release. It returns one `header_data_rsp_t` per command to the control FSM and is the only master on the allocator's memory port.

---
 rtl/falafel_lsu.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_falafel_lsu.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_lsu.sv
// falafel_lsu: load/store unit of the falafel free-list allocator.
//
// Takes one header_data_req_t command at a time from the allocator control
// FSM and turns it into single-word accesses on the allocator memory port.
// The accesses are header loads, header writes, and spin/release of the
// global free-list lock. It returns one header_data_rsp_t per command.
//
// Ports
//   clk_i        : clock, all state changes on the rising edge
//   rst_i        : asynchronous active-high reset
//   req_i        : command (req_i.val = valid)
//   req_ready_o  : a command is accepted this cycle when req_i.val is also high
//   rsp_o        : registered response (rsp_o.val = valid)
//   rsp_ready_i  : consumer takes the response
//   mem_req_o    : memory request valid (registered)
//   mem_we_o     : 1 = write, 0 = read (registered)
//   mem_addr_o   : byte address, word granular (registered)
//   mem_wdata_o  : write data (registered)
//   mem_gnt_i    : memory accepts the request this cycle
//   mem_rvalid_i : read data valid
//   mem_rdata_i  : read data

package falafel_pkg;

    localparam int          DATA_W                 = 64;
    localparam logic [63:0] BLOCK_NEXT_ADDR_OFFSET = 64'd8;

    localparam logic [2:0] OP_LOAD         = 3'd0;
    localparam logic [2:0] OP_UPDATE       = 3'd1;
    localparam logic [2:0] OP_FREE_INSERT  = 3'd2;
    localparam logic [2:0] OP_ALLOC_INSERT = 3'd3;
    localparam logic [2:0] OP_DELETE       = 3'd4;
    localparam logic [2:0] OP_LOCK         = 3'd5;
    localparam logic [2:0] OP_UNLOCK       = 3'd6;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_data_t;

    typedef struct packed {
        logic         val;
        logic [2:0]   op;
        header_data_t header_data;
    } header_data_req_t;

    typedef struct packed {
        logic         val;
        header_data_t header_data;
    } header_data_rsp_t;

endpackage

module falafel_lsu
    import falafel_pkg::*;
#(
    parameter logic [63:0] LOCK_ADDR = 64'h0000_0000_0000_1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  header_data_req_t req_i,
    output logic             req_ready_o,
    output header_data_rsp_t rsp_o,
    input  logic             rsp_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [63:0]      mem_addr_o,
    output logic [63:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [63:0]      mem_rdata_i
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_SIZE   = 4'd1,
        WR_NEXT   = 4'd2,
        RD_SIZE   = 4'd3,
        WAIT_SIZE = 4'd4,
        RD_NEXT   = 4'd5,
        WAIT_NEXT = 4'd6,
        LOCK_RD   = 4'd7,
        LOCK_WAIT = 4'd8,
        LOCK_WR   = 4'd9,
        UNLOCK_WR = 4'd10,
        RSP       = 4'd11
    } state_e;

    state_e           state_q, state_d;
    header_data_req_t cmd_q, cmd_d;
    logic [63:0]      rdata0_q, rdata0_d;
    header_data_rsp_t rsp_q, rsp_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [63:0]      mem_addr_q, mem_addr_d;
    logic [63:0]      mem_wdata_q, mem_wdata_d;
    logic [63:0]      next_field_addr_s;
    header_data_t     rsp_hd_s;

    // Unknown encodings make no memory access and respond straight away.
    function automatic state_e first_state(input logic [2:0] op);
        case (op)
            OP_LOAD:                             first_state = RD_SIZE;
            OP_UPDATE, OP_FREE_INSERT,
            OP_ALLOC_INSERT:                     first_state = WR_SIZE;
            OP_DELETE:                           first_state = WR_NEXT;
            OP_LOCK:                             first_state = LOCK_RD;
            OP_UNLOCK:                           first_state = UNLOCK_WR;
            default:                             first_state = RSP;
        endcase
    endfunction

    // The reset term keeps ready low while reset is asserted, even though the state already reads IDLE.
    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign rsp_o       = rsp_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Next-state logic, command latch and first read-word capture.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        rdata0_d = rdata0_q;
        case (state_q)
            IDLE: begin
                if (req_i.val) begin
                    cmd_d   = req_i;
                    state_d = first_state(req_i.op);
                end else begin
                    state_d = IDLE;
                end
            end
            WR_SIZE: begin
                if (mem_gnt_i) begin
                    state_d = (cmd_q.op == OP_ALLOC_INSERT) ? RSP : WR_NEXT;
                end else begin
                    state_d = WR_SIZE;
                end
            end
            WR_NEXT, LOCK_WR, UNLOCK_WR: begin
                if (mem_gnt_i) begin
                    state_d = RSP;
                end else begin
                    state_d = state_q;
                end
            end
            RD_SIZE: begin
                if (mem_gnt_i) begin
                    state_d = WAIT_SIZE;
                end else begin
                    state_d = RD_SIZE;
                end
            end
            WAIT_SIZE: begin
                if (mem_rvalid_i) begin
                    rdata0_d = mem_rdata_i;
                    state_d  = RD_NEXT;
                end else begin
                    state_d = WAIT_SIZE;
                end
            end
            RD_NEXT: begin
                if (mem_gnt_i) begin
                    state_d = WAIT_NEXT;
                end else begin
                    state_d = RD_NEXT;
                end
            end
            WAIT_NEXT: begin
                if (mem_rvalid_i) begin
                    state_d = RSP;
                end else begin
                    state_d = WAIT_NEXT;
                end
            end
            LOCK_RD: begin
                if (mem_gnt_i) begin
                    state_d = LOCK_WAIT;
                end else begin
                    state_d = LOCK_RD;
                end
            end
            LOCK_WAIT: begin
                // A nonzero lock word means someone else holds it: spin.
                if (mem_rvalid_i) begin
                    state_d = (mem_rdata_i == 64'd0) ? LOCK_WR : LOCK_RD;
                end else begin
                    state_d = LOCK_WAIT;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RSP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory request registers are loaded for the state being entered, so each access appears one cycle after its decision.
    always_comb begin
        next_field_addr_s = cmd_d.header_data.addr + BLOCK_NEXT_ADDR_OFFSET;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 64'd0;
        mem_wdata_d = 64'd0;
        case (state_d)
            WR_SIZE: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = cmd_d.header_data.addr;
                mem_wdata_d = cmd_d.header_data.size;
            end
            WR_NEXT: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = next_field_addr_s;
                mem_wdata_d = cmd_d.header_data.next_addr;
            end
            RD_SIZE: begin
                mem_req_d  = 1'b1;
                mem_addr_d = cmd_d.header_data.addr;
            end
            RD_NEXT: begin
                mem_req_d  = 1'b1;
                mem_addr_d = next_field_addr_s;
            end
            LOCK_RD: begin
                mem_req_d  = 1'b1;
                mem_addr_d = LOCK_ADDR;
            end
            LOCK_WR: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = LOCK_ADDR;
                mem_wdata_d = 64'd1;
            end
            UNLOCK_WR: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = LOCK_ADDR;
                mem_wdata_d = 64'd0;
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Response register: loaded on entry to RSP, cleared on handshake.
    always_comb begin
        case (cmd_d.op)
            OP_LOAD: rsp_hd_s = '{addr: cmd_d.header_data.addr, size: rdata0_q,
                                  next_addr: mem_rdata_i};
            OP_LOCK, OP_UNLOCK: rsp_hd_s = '{addr: LOCK_ADDR, size: 64'd0, next_addr: 64'd0};
            default: rsp_hd_s = cmd_d.header_data;
        endcase
        if ((state_d == RSP) && (state_q != RSP)) begin
            rsp_d.val         = 1'b1;
            rsp_d.header_data = rsp_hd_s;
        end else if ((state_q == RSP) && (state_d == IDLE)) begin
            rsp_d = '0;
        end else begin
            rsp_d = rsp_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rdata0_q    <= 64'd0;
            rsp_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rdata0_q    <= rdata0_d;
            rsp_q       <= rsp_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_falafel_lsu.sv
// Scoreboard bench for falafel_lsu: directed commands push the expected memory
// accesses and responses into queues; a monitor checks what the DUT presents.
module tb_falafel_lsu;
    import falafel_pkg::*;

    localparam logic [63:0] LK = 64'h1000;

    logic             clk = 1'b0;
    logic             rst_i;
    header_data_req_t req_i;
    logic             req_ready_o;
    header_data_rsp_t rsp_o;
    logic             rsp_ready_i;
    logic             mem_req_o, mem_we_o;
    logic [63:0]      mem_addr_o, mem_wdata_o;
    logic             mem_gnt_i, mem_rvalid_i;
    logic [63:0]      mem_rdata_i;

    falafel_lsu #(.LOCK_ADDR(LK)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_ready_o(req_ready_o),
        .rsp_o(rsp_o), .rsp_ready_i(rsp_ready_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          at;
    } acc_t;
    typedef struct {
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next;
        int          at;
    } rspx_t;

    acc_t        acc_q[$];
    rspx_t       rsp_q[$];
    logic [63:0] mem_arr[logic [63:0]];
    logic [63:0] lock_vals[$];
    int          gnt_delay = 0;
    int          rv_delay  = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_acc(input logic we, input logic [63:0] a, input logic [63:0] d, input int at);
        acc_t e;
        e.we = we; e.addr = a; e.wdata = d; e.at = at;
        acc_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic [63:0] a, input logic [63:0] s, input logic [63:0] n, input int at);
        rspx_t e;
        e.addr = a; e.size = s; e.next = n; e.at = at;
        rsp_q.push_back(e);
    endtask

    // Memory model: configurable grant delay and rvalid latency; lock reads pop lock_vals.
    initial begin
        int          gwait;
        bit          rv_pend;
        int          rv_cnt;
        logic [63:0] rv_data;
        gwait = 0; rv_pend = 1'b0; rv_cnt = 0; rv_data = 64'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'd0;
        forever begin
            @(posedge clk); #1;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (rv_pend) begin
                if (rv_cnt <= 1) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rv_data;
                    rv_pend      = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            if (mem_req_o) begin
                if (gwait >= gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    gwait     = 0;
                    if (mem_we_o) begin
                        mem_arr[mem_addr_o] = mem_wdata_o;
                    end else begin
                        rv_pend = 1'b1;
                        rv_cnt  = rv_delay;
                        if (mem_addr_o == LK && lock_vals.size() > 0)
                            rv_data = lock_vals.pop_front();
                        else if (mem_arr.exists(mem_addr_o))
                            rv_data = mem_arr[mem_addr_o];
                        else
                            rv_data = 64'd0;
                    end
                end else begin
                    gwait++;
                end
            end
        end
    end

    // Monitor: compares every presented access and response against the queues.
    initial begin
        bit          prev_val;
        bit          holding;
        logic [63:0] held_wdata;
        prev_val = 1'b0; holding = 1'b0; held_wdata = 64'd0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                if (acc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_access: got we=%0b addr=%h wdata=%h expected none",
                             mem_we_o, mem_addr_o, mem_wdata_o);
                end else begin
                    chk("acc_we", 64'(mem_we_o), 64'(acc_q[0].we));
                    chk("acc_addr", mem_addr_o, acc_q[0].addr);
                    if (acc_q[0].we) chk("acc_wdata", mem_wdata_o, acc_q[0].wdata);
                    if (holding) chk("acc_wdata_stable", mem_wdata_o, held_wdata);
                    held_wdata = mem_wdata_o;
                    holding    = 1'b1;
                    if (mem_gnt_i) begin
                        chk("acc_cycle", 64'(cyc), 64'(acc_q[0].at));
                        void'(acc_q.pop_front());
                        holding = 1'b0;
                    end
                end
            end else begin
                holding = 1'b0;
            end
            if (rsp_o.val) begin
                chk("rsp_mem_req_low", 64'(mem_req_o), 64'd0);
                chk("rsp_req_ready_low", 64'(req_ready_o), 64'd0);
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got addr=%h expected none", rsp_o.header_data.addr);
                end else begin
                    chk("rsp_addr", rsp_o.header_data.addr, rsp_q[0].addr);
                    chk("rsp_size", rsp_o.header_data.size, rsp_q[0].size);
                    chk("rsp_next", rsp_o.header_data.next_addr, rsp_q[0].next);
                    if (!prev_val) chk("rsp_cycle", 64'(cyc), 64'(rsp_q[0].at));
                    if (rsp_ready_i) void'(rsp_q.pop_front());
                end
            end
            prev_val = rsp_o.val;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] s,
                         input logic [63:0] n, output int t);
        @(posedge clk); #1;
        req_i.val = 1'b1;
        req_i.op  = op;
        req_i.header_data.addr      = a;
        req_i.header_data.size      = s;
        req_i.header_data.next_addr = n;
        t = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept expected accept of op %0d", op);
        end
        @(posedge clk); #1;
        req_i = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (acc_q.size() > 0 || rsp_q.size() > 0); i++) @(negedge clk);
        checks++;
        if (acc_q.size() > 0 || rsp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d accesses %0d responses pending expected 0",
                     acc_q.size(), rsp_q.size());
            acc_q.delete();
            rsp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we_o), 64'd0);
        chk({tag, "_mem_addr"}, mem_addr_o, 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 64'd0);
        chk({tag, "_rsp_val"}, 64'(rsp_o.val), 64'd0);
        chk({tag, "_rsp_addr"}, rsp_o.header_data.addr, 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
    endtask

    initial begin
        int t, tb2;
        rst_i = 1'b1; req_i = '0; rsp_ready_i = 1'b1;
        @(negedge clk); @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1; rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready_o), 64'd1);

        // UPDATE: two writes back to back, response in T+3
        issue(OP_UPDATE, 64'h100, 64'h40, 64'h200, t);
        exp_acc(1'b1, 64'h100, 64'h40, t + 1);
        exp_acc(1'b1, 64'h108, 64'h200, t + 2);
        exp_rsp(64'h100, 64'h40, 64'h200, t + 3);
        drain();

        issue(OP_FREE_INSERT, 64'h300, 64'h10, 64'h0, t);
        exp_acc(1'b1, 64'h300, 64'h10, t + 1);
        exp_acc(1'b1, 64'h308, 64'h0, t + 2);
        exp_rsp(64'h300, 64'h10, 64'h0, t + 3);
        drain();

        // LOAD with grant delayed 2 and rvalid 3 after grant: each read costs 4 extra cycles
        mem_arr[64'h100] = 64'h80;
        mem_arr[64'h108] = 64'h300;
        gnt_delay = 2; rv_delay = 3;
        issue(OP_LOAD, 64'h100, 64'hdead, 64'hbeef, t);
        exp_acc(1'b0, 64'h100, 64'd0, t + 3);
        exp_acc(1'b0, 64'h108, 64'd0, t + 9);
        exp_rsp(64'h100, 64'h80, 64'h300, t + 13);
        drain();
        gnt_delay = 0; rv_delay = 1;

        // LOCK spins twice on a busy lock, then takes it
        lock_vals.push_back(64'd1);
        lock_vals.push_back(64'd1);
        lock_vals.push_back(64'd0);
        issue(OP_LOCK, 64'h100, 64'h5, 64'h6, t);
        exp_acc(1'b0, LK, 64'd0, t + 1);
        exp_acc(1'b0, LK, 64'd0, t + 3);
        exp_acc(1'b0, LK, 64'd0, t + 5);
        exp_acc(1'b1, LK, 64'd1, t + 7);
        exp_rsp(LK, 64'd0, 64'd0, t + 8);
        drain();

        issue(OP_UNLOCK, 64'h100, 64'h5, 64'h6, t);
        exp_acc(1'b1, LK, 64'd0, t + 1);
        exp_rsp(LK, 64'd0, 64'd0, t + 2);
        drain();

        issue(OP_DELETE, 64'h100, 64'h55, 64'h0, t);
        exp_acc(1'b1, 64'h108, 64'h0, t + 1);
        exp_rsp(64'h100, 64'h55, 64'h0, t + 2);
        drain();

        issue(OP_ALLOC_INSERT, 64'h100, 64'h40, 64'h999, t);
        exp_acc(1'b1, 64'h100, 64'h40, t + 1);
        exp_rsp(64'h100, 64'h40, 64'h999, t + 2);
        drain();

        // Unknown op: echo, no access, response in T+1
        issue(3'd7, 64'habc, 64'h1, 64'h2, t);
        exp_rsp(64'habc, 64'h1, 64'h2, t + 1);
        drain();

        // Next-field address wraps modulo 2^64
        issue(OP_DELETE, 64'hffff_ffff_ffff_fffc, 64'h0, 64'h77, t);
        exp_acc(1'b1, 64'h4, 64'h77, t + 1);
        exp_rsp(64'hffff_ffff_ffff_fffc, 64'h0, 64'h77, t + 2);
        drain();

        // Consumer stalls the response for 3 cycles while a new command waits
        rsp_ready_i = 1'b0;
        issue(OP_ALLOC_INSERT, 64'h500, 64'h7, 64'h8, t);
        exp_acc(1'b1, 64'h500, 64'h7, t + 1);
        exp_rsp(64'h500, 64'h7, 64'h8, t + 2);
        fork
            begin
                repeat (4) @(posedge clk);
                #1 rsp_ready_i = 1'b1;
            end
        join_none
        issue(OP_UNLOCK, 64'h0, 64'h0, 64'h0, tb2);
        chk("accept_after_handshake", 64'(tb2), 64'(t + 6));
        exp_acc(1'b1, LK, 64'd0, tb2 + 1);
        exp_rsp(LK, 64'd0, 64'd0, tb2 + 2);
        drain();

        // Reset during WAIT_SIZE of a LOAD; the late rvalid must be ignored
        mem_arr[64'h100] = 64'h80;
        rv_delay = 3;
        issue(OP_LOAD, 64'h100, 64'h0, 64'h0, t);
        exp_acc(1'b0, 64'h100, 64'd0, t + 1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", 64'(req_ready_o), 64'd1);
        @(negedge clk);
        chk("late_rvalid_seen", 64'(mem_rvalid_i), 64'd1);
        chk("ready_after_late_rvalid", 64'(req_ready_o), 64'd1);
        repeat (3) @(negedge clk);
        chk("ready_idle_after_late_rvalid", 64'(req_ready_o), 64'd1);
        rv_delay = 1;
        drain();

        issue(OP_UPDATE, 64'h100, 64'h40, 64'h200, t);
        exp_acc(1'b1, 64'h100, 64'h40, t + 1);
        exp_acc(1'b1, 64'h108, 64'h200, t + 2);
        exp_rsp(64'h100, 64'h40, 64'h200, t + 3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
